// File: rtl/tinybmat_pkg.sv
// Shared definitions for the tinybmat issue front-end.
//  - default operand/result width, tag width and FIFO depth
//  - request record layout {xor, rs1, rs2, tag}, tag in the LSBs
//  - issue FSM state encoding
package tinybmat_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned TAGW_DEF  = 5;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Request record field placement, derived from the actual widths.
  function automatic int unsigned req_w(input int unsigned xlen, input int unsigned tagw);
    return 1 + 2 * xlen + tagw;
  endfunction

  function automatic int unsigned rs2_lsb(input int unsigned tagw);
    return tagw;
  endfunction

  function automatic int unsigned rs1_lsb(input int unsigned xlen, input int unsigned tagw);
    return tagw + xlen;
  endfunction

  function automatic int unsigned xor_bit(input int unsigned xlen, input int unsigned tagw);
    return tagw + 2 * xlen;
  endfunction

endpackage

// File: rtl/tinybmat_if.sv
// Bus bundles of the tinybmat issue front-end.
//  tinybmat_core_if : core request (valid/ready) and result (valid/ready) channels.
//    master = core, slave = issue block.
//  tinybmat_unit_if : start/busy/done pulse protocol of the bit-matrix unit.
//    master = issue block, slave = unit.
interface tinybmat_core_if #(
  parameter int unsigned XLEN = tinybmat_pkg::XLEN_DEF,
  parameter int unsigned TAGW = tinybmat_pkg::TAGW_DEF
);
  logic            in_valid;
  logic            in_ready;
  logic            in_xor;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rd;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, in_xor, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_rd, out_tag
  );
  modport slave (
    input  in_valid, in_xor, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_rd, out_tag
  );
endinterface

interface tinybmat_unit_if #(
  parameter int unsigned XLEN = tinybmat_pkg::XLEN_DEF
);
  logic            bm_start;
  logic            bm_xoren;
  logic [XLEN-1:0] bm_rs1;
  logic [XLEN-1:0] bm_rs2;
  logic            bm_busy;
  logic            bm_done;
  logic [XLEN-1:0] bm_rd;

  modport master (
    output bm_start, bm_xoren, bm_rs1, bm_rs2,
    input  bm_busy, bm_done, bm_rd
  );
  modport slave (
    input  bm_start, bm_xoren, bm_rs1, bm_rs2,
    output bm_busy, bm_done, bm_rd
  );
endinterface

// File: rtl/tinybmat_fifo.sv
// Request FIFO for the tinybmat issue front-end.
//  clock/resetn          : clock, asynchronous active-low reset
//  push_valid/push_ready : write handshake, push_ready = !full
//  push_data             : record written on push
//  pop_valid/pop_ready   : read handshake, pop_valid = !empty
//  pop_data              : head record, valid from the edge it was written
// Pointers carry one extra MSB so full and empty are distinguishable.
module tinybmat_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty      = (wptr == rptr);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pop_data   = mem[rptr[AW-1:0]];
  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push    = push_valid && !full;
  assign do_pop     = pop_ready && !empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tinybmat_issue.sv
// Issue front-end for the multicycle bit-matrix unit.
//  clock/resetn : clock, asynchronous active-low reset
//  core         : request channel in (in_*), result channel out (out_*)
//  unit         : registered start pulse + operands out, busy/done/rd in
//  err          : sticky protocol error (stray bm_done, or issue while busy)
// One operation in flight at most; the result slot holds each result
// until the core takes it.
module tinybmat_issue
  import tinybmat_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAGW  = TAGW_DEF
) (
  input  logic            clock,
  input  logic            resetn,
  tinybmat_core_if.slave  core,
  tinybmat_unit_if.master unit,
  output logic            err
);
  localparam int unsigned REQ_W   = req_w(XLEN, TAGW);
  localparam int unsigned RS2_LSB = rs2_lsb(TAGW);
  localparam int unsigned RS1_LSB = rs1_lsb(XLEN, TAGW);
  localparam int unsigned XOR_BIT = xor_bit(XLEN, TAGW);

  state_t           state;
  logic             rdy_en;
  logic             fifo_ready;
  logic             head_valid;
  logic             issue;
  logic             slot_free;
  logic [REQ_W-1:0] in_rec;
  logic [REQ_W-1:0] head;
  logic [TAGW-1:0]  cur_tag;

  assign in_rec        = {core.in_xor, core.in_rs1, core.in_rs2, core.in_tag};
  // in_ready stays low until the first edge after reset.
  assign core.in_ready = rdy_en && fifo_ready;
  assign slot_free     = !core.out_valid || core.out_ready;
  assign issue         = (state == ST_IDLE) && head_valid && slot_free;

  tinybmat_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push_valid (core.in_valid && rdy_en),
    .push_ready (fifo_ready),
    .push_data  (in_rec),
    .pop_valid  (head_valid),
    .pop_ready  (issue),
    .pop_data   (head)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_SYNC;
      rdy_en         <= 1'b0;
      cur_tag        <= '0;
      err            <= 1'b0;
      core.out_valid <= 1'b0;
      core.out_rd    <= '0;
      core.out_tag   <= '0;
      unit.bm_start  <= 1'b0;
      unit.bm_xoren  <= 1'b0;
      unit.bm_rs1    <= '0;
      unit.bm_rs2    <= '0;
    end else begin
      rdy_en        <= 1'b1;
      unit.bm_start <= 1'b0;
      unit.bm_xoren <= 1'b0;
      unit.bm_rs1   <= '0;
      unit.bm_rs2   <= '0;

      if (core.out_valid && core.out_ready) core.out_valid <= 1'b0;

      // A done strobe outside WAIT is flagged and otherwise ignored.
      if (unit.bm_done && (state != ST_WAIT)) err <= 1'b1;

      case (state)
        // Waits out an operation the unit may still be running from
        // before this block was reset.
        ST_SYNC: begin
          if (!unit.bm_busy) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (issue) begin
            unit.bm_start <= 1'b1;
            unit.bm_xoren <= head[XOR_BIT];
            unit.bm_rs1   <= head[RS1_LSB +: XLEN];
            unit.bm_rs2   <= head[RS2_LSB +: XLEN];
            cur_tag       <= head[TAGW-1:0];
            state         <= ST_WAIT;
            if (unit.bm_busy) err <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (unit.bm_done) begin
            core.out_rd    <= unit.bm_rd;
            core.out_tag   <= cur_tag;
            core.out_valid <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_tinybmat_issue.sv
module tb_tinybmat_issue;
  localparam int unsigned XLEN     = 64;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TAGW     = 5;
  localparam int unsigned UNIT_LAT = 8;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic err;

  always #5 clock = ~clock;

  tinybmat_core_if #(.XLEN(XLEN), .TAGW(TAGW)) core_if ();
  tinybmat_unit_if #(.XLEN(XLEN))              unit_if ();

  tinybmat_issue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .core   (core_if),
    .unit   (unit_if),
    .err    (err)
  );

  // Unit model: result ready UNIT_LAT cycles after it samples bm_start.
  int unsigned     m_cnt    = 0;
  logic            m_busy   = 1'b0;
  logic            m_done   = 1'b0;
  logic            m_xor    = 1'b0;
  logic [XLEN-1:0] m_a      = '0;
  logic [XLEN-1:0] m_b      = '0;
  logic [XLEN-1:0] m_rd     = '0;
  logic            inj_done = 1'b0;

  assign unit_if.bm_busy = m_busy;
  assign unit_if.bm_done = m_done | inj_done;
  assign unit_if.bm_rd   = m_rd;

  typedef struct {
    logic [XLEN-1:0] rd;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned pushes    = 0;
  int unsigned starts    = 0;
  int unsigned stalls    = 0;
  int unsigned rst_edges = 0;
  logic            held     = 1'b0;
  logic [XLEN-1:0] held_rd  = '0;
  logic [TAGW-1:0] held_tag = '0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(posedge clock or negedge resetn) begin
    if (!resetn) rst_edges <= 0;
    else if (rst_edges < 2) rst_edges <= rst_edges + 1;
  end

  // Unit model, FIFO occupancy model and result scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (unit_if.bm_start) check("start_while_busy", 64'(m_busy), 64'(0));
    m_done = 1'b0;
    if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_busy = 1'b0;
        m_rd   = m_xor ? (m_a ^ m_b) : (m_a | m_b);
      end
    end
    if (unit_if.bm_start) begin
      m_xor  = unit_if.bm_xoren;
      m_a    = unit_if.bm_rs1;
      m_b    = unit_if.bm_rs2;
      m_cnt  = UNIT_LAT;
      m_busy = 1'b1;
    end

    if (!resetn) begin
      pushes = 0;
      starts = 0;
      held   = 1'b0;
    end else begin
      if (unit_if.bm_start) starts++;
      if (rst_edges > 0)
        check("in_ready", 64'(core_if.in_ready), 64'((pushes - starts) < DEPTH));
      if (core_if.in_valid && core_if.in_ready) pushes++;
      if (core_if.in_valid && !core_if.in_ready) stalls++;

      if (held) begin
        check("hold_valid", 64'(core_if.out_valid), 64'(1));
        check("hold_rd", core_if.out_rd, held_rd);
        check("hold_tag", 64'(core_if.out_tag), 64'(held_tag));
      end
      if (core_if.out_valid && core_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got tag %0d rd %0h, expected no result", core_if.out_tag, core_if.out_rd);
        end else begin
          e = exp_q.pop_front();
          check("out_rd", core_if.out_rd, e.rd);
          check("out_tag", 64'(core_if.out_tag), 64'(e.tag));
        end
      end
      held     = core_if.out_valid && !core_if.out_ready;
      held_rd  = core_if.out_rd;
      held_tag = core_if.out_tag;
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic x, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [TAGW-1:0] tag);
    exp_t e;
    int unsigned waited = 0;
    logic ok = 1'b0;
    core_if.in_valid = 1'b1;
    core_if.in_xor   = x;
    core_if.in_rs1   = a;
    core_if.in_rs2   = b;
    core_if.in_tag   = tag;
    while (!ok && waited < 200) begin
      @(negedge clock);
      if (core_if.in_ready) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      e.rd  = x ? (a ^ b) : (a | b);
      e.tag = tag;
      exp_q.push_back(e);
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no in_ready for tag %0d, expected accept within 200 cycles", tag);
    end
    @(posedge clock);
    #1;
    core_if.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned k = 0;
    while ((exp_q.size() != 0 || core_if.out_valid) && k < 500) begin
      @(posedge clock);
      #1;
      k++;
    end
    check(name, 64'(k < 500), 64'(1));
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected completion before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0;
    int unsigned lat;
    int unsigned k;
    logic rnd_done;

    core_if.in_valid  = 1'b0;
    core_if.in_xor    = 1'b0;
    core_if.in_rs1    = '0;
    core_if.in_rs2    = '0;
    core_if.in_tag    = '0;
    core_if.out_ready = 1'b1;

    // Reset state
    tick(3);
    check("rst_in_ready", 64'(core_if.in_ready), 64'(0));
    check("rst_out_valid", 64'(core_if.out_valid), 64'(0));
    check("rst_out_rd", core_if.out_rd, 64'(0));
    check("rst_out_tag", 64'(core_if.out_tag), 64'(0));
    check("rst_bm_start", 64'(unit_if.bm_start), 64'(0));
    check("rst_bm_xoren", 64'(unit_if.bm_xoren), 64'(0));
    check("rst_bm_rs1", unit_if.bm_rs1, 64'(0));
    check("rst_bm_rs2", unit_if.bm_rs2, 64'(0));
    check("rst_err", 64'(err), 64'(0));
    resetn = 1'b1;
    tick(1);
    check("ready_after_reset", 64'(core_if.in_ready), 64'(1));

    // 1: single request, latency
    s0 = starts;
    send(1'b1, 64'hFF00, 64'h0FF0, 5'd3);
    lat = 0;
    while (!core_if.out_valid && lat < 100) begin
      tick(1);
      lat++;
    end
    check("t1_latency", 64'(lat), 64'(10));
    check("t1_rd", core_if.out_rd, 64'hF0F0);
    check("t1_tag", 64'(core_if.out_tag), 64'(3));
    tick(1);
    check("t1_starts", 64'(starts - s0), 64'(1));

    // 2: burst of 6, FIFO fills
    s0 = stalls;
    for (int unsigned i = 0; i < 6; i++)
      send(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, TAGW'(i));
    check("t2_stalled", 64'(stalls > s0), 64'(1));
    drain("t2_drain");
    check("t2_err", 64'(err), 64'(0));

    // 3: result held with out_ready low
    core_if.out_ready = 1'b0;
    s0 = starts;
    send(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd10);
    send(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd11);
    send(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd12);
    tick(30);
    check("t3_one_op", 64'(starts - s0), 64'(1));
    check("t3_valid", 64'(core_if.out_valid), 64'(1));
    check("t3_rd", core_if.out_rd, exp_q[0].rd);

    // 4: drain and issue on the same edge
    core_if.out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t4_issue_on_drain", 64'(unit_if.bm_start), 64'(1));
    drain("t34_drain");

    // Random traffic with random back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int unsigned i = 0; i < 24; i++) begin
          send(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, TAGW'($urandom));
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 12));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1;
          core_if.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    core_if.out_ready = 1'b1;
    drain("rand_drain");
    check("rand_err", 64'(err), 64'(0));

    // 5: stray done with nothing in flight
    tick(2);
    inj_done = 1'b1;
    tick(1);
    inj_done = 1'b0;
    check("t5_err", 64'(err), 64'(1));
    for (int unsigned i = 0; i < 3; i++) begin
      check("t5_no_result", 64'(core_if.out_valid), 64'(0));
      tick(1);
    end

    // 6: reset while the unit is mid-operation
    send(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd7);
    k = 0;
    while (!unit_if.bm_start && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("t6_started", 64'(unit_if.bm_start), 64'(1));
    tick(3);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("t6_rst_out_valid", 64'(core_if.out_valid), 64'(0));
    check("t6_rst_in_ready", 64'(core_if.in_ready), 64'(0));
    check("t6_rst_err", 64'(err), 64'(0));
    check("t6_rst_bm_start", 64'(unit_if.bm_start), 64'(0));
    check("t6_unit_busy", 64'(m_busy), 64'(1));
    tick(2);
    resetn = 1'b1;
    send(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 5'd9);
    drain("t6_drain");
    check("t6_late_done_err", 64'(err), 64'(1));
    check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
